// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - sequential instruction-fetch front end
// Owns the PC, issues one-cycle-latency imem requests and queues {inst, pc} pairs for decode.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic push, pop, credit_ok;

  // Credits cover queued entries plus the outstanding response; a same-cycle pop is not counted.
  assign credit_ok = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
  assign imem_req  = !rst && !halt && !redirect_valid && credit_ok;
  assign imem_addr = pc_q;
  assign push      = inflight_q && !redirect_valid;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_inst  = inst_mem[head_q];
  assign out_pc    = pc_mem[head_q];
  assign occupancy = count_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]   <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
// Reference is a queue-based cycle model of the fetch rules plus scenario-specific timing checks.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous instruction memory: every word is tagged by its own address.
  always @(posedge clk) imem_rdata <= imem_req ? tag(imem_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_req    = 0;
  logic [31:0] got_q[$];

  logic [31:0] m_pc = 32'h0;
  int          m_inf = 0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] m_q[$];

  // One clock cycle: compare DUT against the model, then advance the model with this cycle's inputs.
  task automatic step();
    logic exp_req;
    #1;
    exp_req = !rst && !halt && !redirect_valid && ((m_q.size() + m_inf) < DEPTH);
    n_checks++;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
    end
    n_checks++;
    if (imem_addr !== m_pc) begin
      n_fail++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
    end
    n_checks++;
    if (out_valid !== (m_q.size() != 0)) begin
      n_fail++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_q.size() != 0);
    end
    n_checks++;
    if (occupancy !== 3'(m_q.size())) begin
      n_fail++; $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy, m_q.size());
    end
    if (m_q.size() != 0) begin
      n_checks++;
      if (out_pc !== m_q[0] || out_inst !== tag(m_q[0])) begin
        n_fail++;
        $display("FAIL head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                 cyc, out_pc, out_inst, m_q[0], tag(m_q[0]));
      end
    end
    if (imem_req === 1'b1) n_req++;
    if (out_valid === 1'b1 && out_ready) got_q.push_back(out_pc);

    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (rst) begin
      m_q.delete(); m_inf = 0; m_pc = 32'h0;
    end else if (redirect_valid) begin
      m_q.delete(); m_inf = 0; m_pc = redirect_pc & ~32'h3;
    end else begin
      if (m_inf != 0) m_q.push_back(m_inf_pc);
      if (exp_req) begin
        m_inf = 1; m_inf_pc = m_pc; m_pc = m_pc + 32'd4;
      end else m_inf = 0;
    end
    @(negedge clk);
    cyc = rst ? 0 : cyc + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state req=%b addr=%h valid=%b occ=%0d exp 0/0/0/0",
               imem_req, imem_addr, out_valid, occupancy);
    end
    step();
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int max_occ = 0;
    out_ready = 1'b1;
    do_reset();
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      step();
    end
    n_checks++;
    if (first_valid != 2) begin
      n_fail++; $display("FAIL stream_latency got=%0d exp=2", first_valid);
    end
    n_checks++;
    if (max_occ > 2) begin
      n_fail++; $display("FAIL stream_occupancy got=%0d exp<=2", max_occ);
    end
    n_checks++;
    if (got_q.size() != 18) begin
      n_fail++; $display("FAIL stream_count got=%0d exp=18", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== 32'(4 * i)) begin
        n_fail++; $display("FAIL stream_pc idx=%0d got=%h exp=%h", i, got_q[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (n_req != DEPTH) begin
      n_fail++; $display("FAIL bp_req_count got=%0d exp=%0d", n_req, DEPTH);
    end
    #1;
    n_checks++;
    if (occupancy !== 3'(DEPTH)) begin
      n_fail++; $display("FAIL bp_full got=%0d exp=%0d", occupancy, DEPTH);
    end
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== 32'(4 * i)) begin
        n_fail++; $display("FAIL bp_drain idx=%0d got=%h exp=%h",
                           i, (i < got_q.size()) ? got_q[i] : 32'hX, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    #1;
    n_checks++;
    if (occupancy !== 3'd3) begin
      n_fail++; $display("FAIL redir_pre_occ got=%0d exp=3", occupancy);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_flush occ=%0d req=%b addr=%h exp 0/1/00000100",
                         occupancy, imem_req, imem_addr);
    end
    step();
    step();
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== tag(32'h100)) begin
      n_fail++; $display("FAIL redir_target valid=%b pc=%h inst=%h exp 1/00000100/%h",
                         out_valid, out_pc, out_inst, tag(32'h100));
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_align_wrap();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL align got=%h exp=00000100", imem_addr);
    end
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_halt();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    halt = 1'b1;
    n_req = 0;
    got_q.delete();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (n_req != 0) begin
      n_fail++; $display("FAIL halt_req got=%0d exp=0", n_req);
    end
    n_checks++;
    if (got_q.size() != 2 || got_q[got_q.size()-1] !== 32'd20) begin
      n_fail++; $display("FAIL halt_inflight got_n=%0d exp_n=2 last_exp=00000014", got_q.size());
    end
    halt = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd24) begin
      n_fail++; $display("FAIL halt_resume req=%b addr=%h exp 1/00000018", imem_req, imem_addr);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid valid=%b occ=%0d req=%b addr=%h exp 0/0/1/00000000",
                         out_valid, occupancy, imem_req, imem_addr);
    end
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_restart got_n=%0d exp first pc 00000000", got_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
